// File: rtl/pcie_hcmd_cpl_cid_lookup.sv
//==============================================================================
// Module      : pcie_hcmd_cpl_cid_lookup
// Description : Looks up {SQ ID, CID} for a completing slot tag in the host
//               command CID table and presents an assembled completion record.
//               Optional macro PCIE_HCMD_CPL_CID_BYPASS_EN forwards snooped
//               table writes that hit the slot being looked up.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pcie_hcmd_cpl_cid_lookup #(
    parameter int P_SLOT_TAG_WIDTH = 10,
    parameter int P_CID_WIDTH      = 16,
    parameter int P_QID_WIDTH      = 4,
    parameter int P_DATA_WIDTH     = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpl_req_valid,
    output logic                        cpl_req_ready,
    input  logic [P_SLOT_TAG_WIDTH-1:0] cpl_req_slot_tag,
    input  logic [14:0]                 cpl_req_status,
    input  logic [31:0]                 cpl_req_dw0,
    output logic [P_SLOT_TAG_WIDTH-1:0] cid_rd_addr,
    input  logic [P_DATA_WIDTH-1:0]     cid_rd_data,
    input  logic                        cid_wr_en,
    input  logic [P_SLOT_TAG_WIDTH-1:0] cid_wr_addr,
    input  logic [P_DATA_WIDTH-1:0]     cid_wr_data,
    output logic                        cpl_valid,
    input  logic                        cpl_ready,
    output logic [P_QID_WIDTH-1:0]      cpl_sq_qid,
    output logic [P_CID_WIDTH-1:0]      cpl_cid,
    output logic [14:0]                 cpl_status,
    output logic [31:0]                 cpl_dw0
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RD_CAPT = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]                  r_state;
    logic [1:0]                  w_next_state;
    logic [P_SLOT_TAG_WIDTH-1:0] r_slot_tag;
    logic [14:0]                 r_status;
    logic [31:0]                 r_dw0;
    logic [P_QID_WIDTH-1:0]      r_qid;
    logic [P_CID_WIDTH-1:0]      r_cid;
    logic                        w_accept;
    logic                        w_capture;
    logic [P_DATA_WIDTH-1:0]     w_cap_data;

    assign w_accept  = (r_state == S_IDLE) && cpl_req_valid;
    assign w_capture = (r_state == S_RD_CAPT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (cpl_req_valid) w_next_state = S_RD_WAIT;
            S_RD_WAIT: w_next_state = S_RD_CAPT;
            S_RD_CAPT: w_next_state = S_OUT;
            S_OUT:     if (cpl_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decode the state register only.
    always_comb begin
        cpl_req_ready = 1'b0;
        cpl_valid     = 1'b0;
        case (r_state)
            S_IDLE:  cpl_req_ready = 1'b1;
            S_OUT:   cpl_valid     = 1'b1;
            default: begin
                cpl_req_ready = 1'b0;
                cpl_valid     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_tag <= '0;
            r_status   <= '0;
            r_dw0      <= '0;
        end else if (w_accept) begin
            r_slot_tag <= cpl_req_slot_tag;
            r_status   <= cpl_req_status;
            r_dw0      <= cpl_req_dw0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qid <= '0;
            r_cid <= '0;
        end else if (w_capture) begin
            r_qid <= w_cap_data[P_DATA_WIDTH-1 -: P_QID_WIDTH];
            r_cid <= w_cap_data[P_CID_WIDTH-1:0];
        end
    end

`ifdef PCIE_HCMD_CPL_CID_BYPASS_EN
    logic                    w_wr_hit;
    logic                    r_byp_valid;
    logic [P_DATA_WIDTH-1:0] r_byp_data;

    assign w_wr_hit = cid_wr_en && (cid_wr_addr == r_slot_tag) &&
                      ((r_state == S_RD_WAIT) || (r_state == S_RD_CAPT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_valid <= 1'b0;
            r_byp_data  <= '0;
        end else if (w_next_state == S_IDLE) begin
            r_byp_valid <= 1'b0;
        end else if (w_wr_hit) begin
            r_byp_valid <= 1'b1;
            r_byp_data  <= cid_wr_data;
        end
    end

    // A write landing in the capture cycle itself is newer than anything registered.
    always_comb begin
        w_cap_data = cid_rd_data;
        if (w_capture && w_wr_hit) begin
            w_cap_data = cid_wr_data;
        end else if (r_byp_valid) begin
            w_cap_data = r_byp_data;
        end
    end
`else
    logic w_unused_snoop;

    assign w_unused_snoop = ^{cid_wr_en, cid_wr_addr, cid_wr_data};
    assign w_cap_data     = cid_rd_data;
`endif

    assign cid_rd_addr = r_slot_tag;
    assign cpl_sq_qid  = r_qid;
    assign cpl_cid     = r_cid;
    assign cpl_status  = r_status;
    assign cpl_dw0     = r_dw0;

endmodule

`default_nettype wire

// File: tb/tb_pcie_hcmd_cpl_cid_lookup.sv
//==============================================================================
// Module      : tb_pcie_hcmd_cpl_cid_lookup
// Description : Scoreboard bench for pcie_hcmd_cpl_cid_lookup with a
//               READ_FIRST synchronous table model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pcie_hcmd_cpl_cid_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpl_req_valid;
    logic        cpl_req_ready;
    logic [9:0]  cpl_req_slot_tag;
    logic [14:0] cpl_req_status;
    logic [31:0] cpl_req_dw0;
    logic [9:0]  cid_rd_addr;
    logic [19:0] cid_rd_data;
    logic        cid_wr_en;
    logic [9:0]  cid_wr_addr;
    logic [19:0] cid_wr_data;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [3:0]  cpl_sq_qid;
    logic [15:0] cpl_cid;
    logic [14:0] cpl_status;
    logic [31:0] cpl_dw0;

    typedef struct packed {
        logic [3:0]  q;
        logic [15:0] c;
        logic [14:0] s;
        logic [31:0] d;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [19:0] mem [0:1023];

    pcie_hcmd_cpl_cid_lookup #(
        .P_SLOT_TAG_WIDTH(10),
        .P_CID_WIDTH     (16),
        .P_QID_WIDTH     (4),
        .P_DATA_WIDTH    (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpl_req_valid   (cpl_req_valid),
        .cpl_req_ready   (cpl_req_ready),
        .cpl_req_slot_tag(cpl_req_slot_tag),
        .cpl_req_status  (cpl_req_status),
        .cpl_req_dw0     (cpl_req_dw0),
        .cid_rd_addr     (cid_rd_addr),
        .cid_rd_data     (cid_rd_data),
        .cid_wr_en       (cid_wr_en),
        .cid_wr_addr     (cid_wr_addr),
        .cid_wr_data     (cid_wr_data),
        .cpl_valid       (cpl_valid),
        .cpl_ready       (cpl_ready),
        .cpl_sq_qid      (cpl_sq_qid),
        .cpl_cid         (cpl_cid),
        .cpl_status      (cpl_status),
        .cpl_dw0         (cpl_dw0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // READ_FIRST table: the read returns the pre-write contents.
    always @(posedge clk) begin
        if (cid_wr_en) mem[cid_wr_addr] <= cid_wr_data;
        cid_rd_data <= mem[cid_rd_addr];
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cpl_valid && cpl_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", 72'd1, 72'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("record", {cpl_sq_qid, cpl_cid, cpl_status, cpl_dw0}, mon_e);
            end
        end
    end

    task automatic tbl_write(input logic [9:0] addr, input logic [19:0] data);
        cid_wr_en   = 1'b1;
        cid_wr_addr = addr;
        cid_wr_data = data;
        @(posedge clk); #1;
        cid_wr_en   = 1'b0;
    endtask

    // Issues one request and checks acceptance and the 2-clk valid latency.
    // Returns at #1 after the edge that raises cpl_valid.
    task automatic issue(input logic [9:0] tag, input logic [14:0] st, input logic [31:0] dw,
                         input logic [19:0] entry, input logic do_wr, input logic [19:0] wdata,
                         output int acc);
        int t;
        t = 0;
        exp_q.push_back({entry[19:16], entry[15:0], st, dw});
        cpl_req_slot_tag = tag;
        cpl_req_status   = st;
        cpl_req_dw0      = dw;
        cpl_req_valid    = 1'b1;
        while (!cpl_req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cpl_req_ready) begin
            check("accept_timeout", 72'd0, 72'd1);
            cpl_req_valid = 1'b0;
            void'(exp_q.pop_back());
            acc = cyc;
            return;
        end
        @(posedge clk); #1;
        acc           = cyc;
        cpl_req_valid = 1'b0;
        check("lat_e0_valid", cpl_valid, 0);
        check("ready_low_after_accept", cpl_req_ready, 0);
        if (do_wr) begin
            cid_wr_en   = 1'b1;
            cid_wr_addr = tag;
            cid_wr_data = wdata;
        end
        @(posedge clk); #1;
        cid_wr_en = 1'b0;
        check("lat_e1_valid", cpl_valid, 0);
        check("rd_addr", cid_rd_addr, tag);
        @(posedge clk); #1;
        check("lat_e2_valid", cpl_valid, 1);
    endtask

    initial begin
        int a0;
        int a1;
        logic [19:0] coll_exp;

        rst              = 1'b1;
        cpl_req_valid    = 1'b0;
        cpl_req_slot_tag = '0;
        cpl_req_status   = '0;
        cpl_req_dw0      = '0;
        cid_wr_en        = 1'b0;
        cid_wr_addr      = '0;
        cid_wr_data      = '0;
        cpl_ready        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", cpl_valid, 0);
        check("rst_ready", cpl_req_ready, 1);
        check("rst_rd_addr", cid_rd_addr, 0);
        check("rst_data", {cpl_sq_qid, cpl_cid, cpl_status, cpl_dw0}, 0);
        rst = 1'b0;

        tbl_write(10'h005, 20'h3ABCD);
        tbl_write(10'h3FF, 20'hF0001);
        tbl_write(10'h000, 20'h00002);
        tbl_write(10'h010, 20'h1AAAA);
        tbl_write(10'h020, 20'h7BEEF);

        // Single lookup
        issue(10'h005, 15'h0000, 32'h12345678, 20'h3ABCD, 1'b0, 20'h0, a0);
        @(posedge clk); #1;
        check("ready_return", cpl_req_ready, 1);
        check("valid_fall", cpl_valid, 0);

        // Downstream stall with a competing request held
        cpl_ready = 1'b0;
        issue(10'h005, 15'h1234, 32'hCAFEF00D, 20'h3ABCD, 1'b0, 20'h0, a0);
        cpl_req_valid    = 1'b1;
        cpl_req_slot_tag = 10'h020;
        cpl_req_status   = 15'h7FFF;
        cpl_req_dw0      = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", cpl_valid, 1);
            check("stall_ready", cpl_req_ready, 0);
            check("stall_data", {cpl_sq_qid, cpl_cid, cpl_status, cpl_dw0},
                  {4'h3, 16'hABCD, 15'h1234, 32'hCAFEF00D});
            check("stall_rd_addr", cid_rd_addr, 10'h005);
            @(posedge clk); #1;
        end
        cpl_req_valid = 1'b0;
        cpl_ready     = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", cpl_valid, 0);
        check("stall_release_ready", cpl_req_ready, 1);

        // Back-to-back on the extreme slot tags
        issue(10'h3FF, 15'h0002, 32'h00000001, 20'hF0001, 1'b0, 20'h0, a0);
        issue(10'h000, 15'h0003, 32'h00000002, 20'h00002, 1'b0, 20'h0, a1);
        check("b2b_spacing", a1 - a0, 4);
        @(posedge clk); #1;

        // Table write to the same slot during RD_WAIT
`ifdef PCIE_HCMD_CPL_CID_BYPASS_EN
        coll_exp = 20'h15555;
`else
        coll_exp = 20'h1AAAA;
`endif
        issue(10'h010, 15'h0055, 32'hA5A5A5A5, coll_exp, 1'b1, 20'h15555, a0);
        @(posedge clk); #1;

        // Reset during RD_CAPT drops the request
        cpl_req_slot_tag = 10'h3FF;
        cpl_req_status   = 15'h0011;
        cpl_req_dw0      = 32'h55AA55AA;
        cpl_req_valid    = 1'b1;
        @(posedge clk); #1;
        cpl_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", cpl_valid, 0);
        check("midrst_ready", cpl_req_ready, 1);
        check("midrst_rd_addr", cid_rd_addr, 0);
        check("midrst_data", {cpl_sq_qid, cpl_cid, cpl_status, cpl_dw0}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(10'h020, 15'h0007, 32'hDEADBEEF, 20'h7BEEF, 1'b0, 20'h0, a0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
